// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand bypass and load-use interlock.
// Captures register-file read data, immediate and control for the instruction in ID,
// forwards EX/MEM and WB results onto the EX operands, and inserts a one-cycle
// bubble when the instruction in ID depends on a load currently in EX.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   id_*                     instruction fields from ID (register-file read data, imm, control)
//   flush                    kill the instruction in ID (branch taken)
//   exm_*                    EX/MEM destination/control/result for forwarding
//   wb_*                     write-back port, used for forwarding and capture-time bypass
//   stall                    combinational: hold PC and IF/ID this cycle
//   ex_*                     latched instruction fields; ex_opa/ex_opb are forwarded operands
//   stall_count, flush_count saturating performance event counters
module id_ex_stage #(
  parameter int unsigned WORD = 32,
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic [WORD-1:0] id_regd1,
  input  logic [WORD-1:0] id_regd2,
  input  logic [WORD-1:0] id_imm,
  input  logic            id_use_rt,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [3:0]      id_alu_op,
  input  logic            flush,
  input  logic            exm_reg_write,
  input  logic            exm_mem_read,
  input  logic [REGW-1:0] exm_rd,
  input  logic [WORD-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [WORD-1:0] wb_data,
  output logic            stall,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [3:0]      ex_alu_op,
  output logic [REGW-1:0] ex_rs,
  output logic [REGW-1:0] ex_rt,
  output logic [REGW-1:0] ex_rd,
  output logic [WORD-1:0] ex_imm,
  output logic [WORD-1:0] ex_opa,
  output logic [WORD-1:0] ex_opb,
  output logic [CNTW-1:0] stall_count,
  output logic [CNTW-1:0] flush_count
);

  logic            r_valid;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic [3:0]      r_alu_op;
  logic [REGW-1:0] r_rs;
  logic [REGW-1:0] r_rt;
  logic [REGW-1:0] r_rd;
  logic [WORD-1:0] r_imm;
  logic [WORD-1:0] r_opa;
  logic [WORD-1:0] r_opb;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_flush_cnt;

  logic            w_haz;
  logic            w_stall;
  logic            w_bubble;
  logic [WORD-1:0] w_cap_a;
  logic [WORD-1:0] w_cap_b;

  // Load in EX whose destination is a live source of the instruction in ID
  assign w_haz = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                 ((r_rd == id_rs) || (id_use_rt && (r_rd == id_rt)));

  // Flush wins over the interlock; stale EX contents must not stall during reset
  assign w_stall  = w_haz && !flush && rst;
  assign w_bubble = flush || w_haz;

  // Capture-time bypass so the latch does not depend on the register-file write edge
  assign w_cap_a = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs)) ? wb_data : id_regd1;
  assign w_cap_b = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt)) ? wb_data : id_regd2;

  // ID/EX latch and event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_op    <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_bubble) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_alu_op    <= '0;
        r_rs        <= '0;
        r_rt        <= '0;
        r_rd        <= '0;
        r_imm       <= '0;
        r_opa       <= '0;
        r_opb       <= '0;
      end else begin
        r_valid     <= id_valid;
        r_reg_write <= id_reg_write && id_valid;
        r_mem_read  <= id_mem_read && id_valid;
        r_mem_write <= id_mem_write && id_valid;
        r_alu_op    <= id_alu_op;
        r_rs        <= id_rs;
        r_rt        <= id_rt;
        r_rd        <= id_rd;
        r_imm       <= id_imm;
        r_opa       <= w_cap_a;
        r_opb       <= w_cap_b;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end
      if (flush && id_valid && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNTW'(1);
      end
    end
  end

  // EX operand forwarding: EX/MEM ALU result (not load data) first, then WB
  always_comb begin
    ex_opa = r_opa;
    if (exm_reg_write && !exm_mem_read && (exm_rd != '0) && (exm_rd == r_rs)) begin
      ex_opa = exm_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == r_rs)) begin
      ex_opa = wb_data;
    end
  end

  always_comb begin
    ex_opb = r_opb;
    if (exm_reg_write && !exm_mem_read && (exm_rd != '0) && (exm_rd == r_rt)) begin
      ex_opb = exm_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == r_rt)) begin
      ex_opb = wb_data;
    end
  end

  assign stall        = w_stall;
  assign ex_valid     = r_valid;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign ex_mem_write = r_mem_write;
  assign ex_alu_op    = r_alu_op;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_rd        = r_rd;
  assign ex_imm       = r_imm;
  assign stall_count  = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand bypass and load-use interlock, sitting directly downstream of the register file in the five-stage pipeline. It captures the two register-file read words, immediate and control for the instruction in ID. It presents forwarded operands to the ALU in EX and inserts a one-cycle bubble on a load-use hazard. It also keeps saturating stall and flush event counters for the performance monitor.

## Interface
- WORD, 32, datapath width (matches `WORD` in constants.v)
- REGW, 5, register index width
- CNTW, 16, event counter width
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous reset, active-low (rst==0 at a posedge resets)
- id_valid  input  1  ID holds a real instruction
- id_rs, id_rt, id_rd  input  REGW  source/destination indices (id_rs/id_rt also drive register-file reg1/reg2)
- id_regd1, id_regd2  input  WORD  register-file read data for id_rs/id_rt
- id_imm  input  WORD  sign-extended immediate
- id_use_rt  input  1  instruction reads id_rt as a source
- id_reg_write, id_mem_read, id_mem_write  input  1  control bits
- id_alu_op  input  4  ALU opcode
- flush  input  1  branch taken; kill instruction in ID
- exm_reg_write, exm_mem_read  input  1  EX/MEM control
- exm_rd  input  REGW; exm_result  input  WORD  EX/MEM destination and ALU result
- wb_reg_write  input  1; wb_rd  input  REGW; wb_data  input  WORD  write-back port (same signals as register-file write)
- stall  output  1  hold PC and IF/ID this cycle
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  output  1  latched control
- ex_alu_op  output  4; ex_rs, ex_rt, ex_rd  output  REGW; ex_imm  output  WORD
- ex_opa, ex_opb  output  WORD  forwarded operands
- stall_count, flush_count  output  CNTW  saturating event counters

## Operation
- Hazard: haz = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | (id_use_rt & ex_rd==id_rt)).
- stall = haz & ~flush (combinational).
- Capture at posedge, priority top-down:
  - rst==0: all ex_* registers, both counters = 0.
  - flush or haz: bubble, i.e. ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0, data fields don't-care (drive 0).
  - else: latch all id_* fields; ex_valid = id_valid; control bits ANDed with id_valid.
- Capture-time WB bypass: if wb_reg_write & wb_rd!=0 & wb_rd==id_rs, latched opa = wb_data, else id_regd1; same for rt/opb. Makes capture independent of register-file write edge.
- EX operand mux, combinational from latched values, for ex_opa (ex_rs), same for ex_opb (ex_rt):
  - First: exm_result if exm_reg_write & ~exm_mem_read & exm_rd!=0 & exm_rd==ex_rs.
  - Else: wb_data if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs.
  - Else: latched value.
- Register 0 is never a forward target or hazard source.
- Counters, increment when not in reset, saturate at all-ones:
  - stall_count +1 per cycle stall==1.
  - flush_count +1 per cycle flush==1 & id_valid.

## Timing
- ID to EX latency: 1 cycle.
- stall lasts exactly 1 cycle per load-use: next cycle EX holds the bubble, so haz clears. The dependent instruction then enters EX while the load is in WB and takes wb_data.
- flush and haz in the same cycle: flush wins, stall=0, one bubble, flush_count +1, stall_count unchanged.
- Reset mid-operation discards the instruction in EX. stall=0 during reset cycles.
- Reset values: all ex_* = 0, ex_opa/ex_opb = 0 (no forward active), stall = 0, counters = 0.
- Outputs ex_opa/ex_opb change combinationally within the cycle as exm/wb inputs change. No registered output beyond the ID/EX latch.

## Test plan
- Reset: rst=0 one cycle with id_valid=1 -> next cycle ex_valid=0, ex_opa=0, stall_count=0, flush_count=0.
- EX/MEM forward: latch add rs=3 (id_regd1=5); in EX drive exm_reg_write=1, exm_rd=3, exm_result=0x2A, wb_rd=3, wb_data=0x11 -> ex_opa=0x2A. Same with exm_rd=0 -> ex_opa=0x11.
- Load-use: lw r4 in EX (ex_mem_read=1, ex_rd=4), ID add rs=4 -> stall=1 one cycle, bubble next cycle, stall_count=1. Two cycles later with wb_rd=4, wb_data=0xDEAD -> ex_opa=0xDEAD.
- Flush plus hazard: same load-use setup with flush=1 -> stall=0, ex_valid=0 next cycle, flush_count=1, stall_count=0.
- Capture-time bypass: id_rs=7, id_regd1=0, wb_reg_write=1, wb_rd=7, wb_data=0x99 -> latched operand 0x99. With exm/wb idle next cycle, ex_opa=0x99.
- Saturation: preload stall_count to 0xFFFE by forcing 65534 hazard cycles, then 3 more -> stall_count holds 0xFFFF.
